// File: rtl/jtbubl_obj_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtbubl_obj_pkg
//  Description : Shared constants and reader state encoding for the object
//                line buffer (background value, transparent pen nibble,
//                reader/erase FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package jtbubl_obj_pkg;

    // Background colour index: erase value and blanking output value
    localparam logic [7:0] c_BG_DEFAULT     = 8'hFF;
    // Pen nibble that marks a transparent (never written) pixel
    localparam logic [3:0] c_TRANSP_DEFAULT = 4'hF;
    // Line buffer geometry: 256 pixels per bank, two banks
    localparam int unsigned c_X_W   = 8;
    localparam int unsigned c_RAM_AW = c_X_W + 1;

    // Reader state encoding. CLEAR is the power-on/reset sweep; the other
    // four states form the per-pixel read/capture/erase sequence.
    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_ERASE = 3'd4
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/jtframe_dual_ram.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dual_ram
//  Description : Dual-port synchronous RAM on a single clock.
//                Port 0 : write-only  (i_addr0, i_data0, i_we0)
//                Port 1 : read/write  (i_addr1, i_data1, i_we1, o_q1)
//                Reads are registered (one clk latency) and return the old
//                contents on a same-address read/write.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_dual_ram #(
    parameter int DW = 8,
    parameter int AW = 9
)(
    input  logic          clk,
    // port 0
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_data0,
    input  logic          i_we0,
    // port 1
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_data1,
    input  logic          i_we1,
    output logic [DW-1:0] o_q1
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_q1_q;

    // Both ports share one clock, so a single process keeps the array
    // single-driven. The two ports never target the same address in use.
    always_ff @(posedge clk) begin
        if (i_we0) begin
            r_mem[i_addr0] <= i_data0;
        end
        if (i_we1) begin
            r_mem[i_addr1] <= i_data1;
        end
        r_q1_q <= r_mem[i_addr1];
    end

    assign o_q1 = r_q1_q;

endmodule
`default_nettype wire

// File: rtl/jtbubl_obj_linebuf.sv
`default_nettype none
// ============================================================================
//  Module      : jtbubl_obj_linebuf
//  Description : Double-buffered object line buffer. The draw engine writes
//                colour indices for the next line into bank wbank while the
//                other bank is scanned out one pixel per pxl_cen and erased
//                to background behind the scan. Banks swap on the falling
//                edge of LHBL.
//  Ports       : clk, rst        - clock, async active-high reset
//                pxl_cen         - pixel clock enable (>= 3 clk apart)
//                LHBL            - horizontal blank, active low
//                hdump           - x of the pixel being displayed
//                wr_addr/wr_data - write position / colour index
//                wr_valid/wr_ready - write handshake
//                line_start      - one-clk pulse on the bank swap
//                col_addr        - colour index to the mixer
//  Revision    : 1.0 - initial release
// ============================================================================
module jtbubl_obj_linebuf
    import jtbubl_obj_pkg::*;
#(
    parameter logic [7:0] BG     = c_BG_DEFAULT,
    parameter logic [3:0] TRANSP = c_TRANSP_DEFAULT
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic [7:0] hdump,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic       line_start,
    output logic [7:0] col_addr
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rd_state_e          r_state_q,    w_state_d;
    logic [c_X_W-1:0]   r_clr_cnt_q,  w_clr_cnt_d;
    logic               r_wbank_q,    w_wbank_d;
    logic               r_lhbl_q,     w_lhbl_d;
    logic [c_RAM_AW-1:0] r_rd_addr_q, w_rd_addr_d;
    logic [7:0]         r_hold_q,     w_hold_d;
    logic [7:0]         r_col_addr_q, w_col_addr_d;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic w_run;
    logic w_swap;
    logic w_rd_start;
    logic w_rd_free;

    assign w_run  = (r_state_q != ST_CLEAR);
    // Falling edge of LHBL, ignored during the CLEAR sweep
    assign w_swap = w_run & r_lhbl_q & ~LHBL;

    // The erase write lands on the ERASE entry edge, so ERASE can already
    // accept the next pixel; this lets pxl_cen pulses be exactly 3 clk apart.
    assign w_rd_free  = (r_state_q == ST_IDLE) | (r_state_q == ST_ERASE);
    assign w_rd_start = w_rd_free & LHBL & pxl_cen;

    // Stall writes on the swap cycle so they land in the new bank
    assign wr_ready   = w_run & ~w_swap;
    assign line_start = w_swap;
    assign col_addr   = r_col_addr_q;

    // ------------------------------------------------------------------
    // RAM ports
    // ------------------------------------------------------------------
    logic [c_RAM_AW-1:0] w_addr0, w_addr1;
    logic [7:0]          w_data0, w_data1;
    logic                w_we0,   w_we1;
    logic [7:0]          w_ram_q;

    always_comb begin
        w_addr0 = {r_wbank_q, wr_addr};
        w_data0 = wr_data;
        w_we0   = wr_valid & wr_ready & (wr_data[3:0] != TRANSP);
        // In the free states the read port tracks the live pixel so the
        // data is ready one clk after pxl_cen; later states use the
        // latched address (bank included) for capture and erase.
        w_addr1 = w_rd_free ? {~r_wbank_q, hdump} : r_rd_addr_q;
        w_data1 = BG;
        w_we1   = (r_state_q == ST_CAPT);

        if (r_state_q == ST_CLEAR) begin
            // Sweep both banks in parallel, one location per port per clk
            w_addr0 = {1'b0, r_clr_cnt_q};
            w_data0 = BG;
            w_we0   = 1'b1;
            w_addr1 = {1'b1, r_clr_cnt_q};
            w_data1 = BG;
            w_we1   = 1'b1;
        end
    end

    jtframe_dual_ram #(
        .DW (8),
        .AW (c_RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_addr0 (w_addr0),
        .i_data0 (w_data0),
        .i_we0   (w_we0),
        .i_addr1 (w_addr1),
        .i_data1 (w_data1),
        .i_we1   (w_we1),
        .o_q1    (w_ram_q)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_clr_cnt_d  = r_clr_cnt_q;
        w_wbank_d    = r_wbank_q ^ w_swap;
        w_lhbl_d     = LHBL;
        w_rd_addr_d  = r_rd_addr_q;
        w_hold_d     = r_hold_q;
        w_col_addr_d = r_col_addr_q;

        case (r_state_q)
            ST_CLEAR: begin
                w_clr_cnt_d = r_clr_cnt_q + 8'd1;
                if (r_clr_cnt_q == 8'hFF) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_ERASE: begin
                if (w_rd_start) begin
                    // Output the previous pixel: one pixel of latency
                    w_rd_addr_d  = {~r_wbank_q, hdump};
                    w_col_addr_d = r_hold_q;
                    w_state_d    = ST_READ;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                w_hold_d  = w_ram_q;
                w_state_d = ST_CAPT;
            end
            ST_CAPT: begin
                w_state_d = ST_ERASE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Blanking: park the reader, clear the hold register so the first
        // pixel of the next line is background, and drive background out.
        if (w_run && !LHBL) begin
            w_state_d = ST_IDLE;
            w_hold_d  = BG;
            if (pxl_cen) begin
                w_col_addr_d = BG;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= ST_CLEAR;
            r_clr_cnt_q  <= '0;
            r_wbank_q    <= 1'b0;
            r_lhbl_q     <= 1'b0;
            r_rd_addr_q  <= '0;
            r_hold_q     <= BG;
            r_col_addr_q <= BG;
        end else begin
            r_state_q    <= w_state_d;
            r_clr_cnt_q  <= w_clr_cnt_d;
            r_wbank_q    <= w_wbank_d;
            r_lhbl_q     <= w_lhbl_d;
            r_rd_addr_q  <= w_rd_addr_d;
            r_hold_q     <= w_hold_d;
            r_col_addr_q <= w_col_addr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtbubl_obj_linebuf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtbubl_obj_linebuf
//  Description : Self-checking bench for jtbubl_obj_linebuf. A two-bank
//                array model holds what each line should display; scanning
//                a pixel returns the model value and erases it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtbubl_obj_linebuf;

    localparam logic [7:0] C_BG = 8'hFF;
    localparam logic [3:0] C_TR = 4'hF;

    logic       clk = 1'b0;
    logic       rst;
    logic       pxl_cen;
    logic       LHBL;
    logic [7:0] hdump;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       line_start;
    logic [7:0] col_addr;

    int n_cmp = 0;
    int n_err = 0;

    // Model: bank contents and which bank the writer owns
    logic [7:0] m_bank [2][256];
    bit         m_wb;
    // col_addr seen at the pxl_cen sampling hdump = x
    logic [7:0] obs [256];

    always #5 clk = ~clk;

    jtbubl_obj_linebuf dut (
        .clk        (clk),
        .rst        (rst),
        .pxl_cen    (pxl_cen),
        .LHBL       (LHBL),
        .hdump      (hdump),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .line_start (line_start),
        .col_addr   (col_addr)
    );

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int x = 0; x < 256; x++)
                m_bank[b][x] = C_BG;
        m_wb = 1'b0;
    endtask

    function automatic int count_nonbg();
        int n = 0;
        for (int x = 0; x < 256; x++)
            if (obs[x] !== C_BG) n++;
        return n;
    endfunction

    // Optional random write; caller guarantees wr_ready is expected high
    task automatic drive_rand_write(input int prob);
        if ($urandom_range(0, 99) < prob) begin
            wr_valid = 1'b1;
            wr_addr  = 8'($urandom);
            wr_data  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) wr_data[3:0] = C_TR;
            if (wr_data[3:0] != C_TR) m_bank[m_wb][wr_addr] = wr_data;
        end else begin
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_clear(input string tag);
        int cyc = 0;
        while (wr_ready !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != 256) begin
            n_err++;
            $display("FAIL %s clear_len: wr_ready low for %0d cycles, expected 256", tag, cyc);
        end
    endtask

    task automatic do_write(input logic [7:0] x, input logic [7:0] d);
        @(negedge clk);
        pxl_cen = 1'b0; wr_valid = 1'b1; wr_addr = x; wr_data = d;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL write_ready x=%0d: wr_ready=%b expected 1", x, wr_ready);
        end
        if (d[3:0] != C_TR) m_bank[m_wb][x] = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Scan one full line. rst_at >= 0 asserts rst when hdump reaches it.
    task automatic scan_line(input int prob, input int rst_at);
        logic [7:0] hold_m;
        logic [7:0] exp_col;
        bit         rb;
        int         gap;
        hold_m  = C_BG;
        exp_col = C_BG;
        for (int x = 0; x < 256; x++) begin
            gap = $urandom_range(3, 5);
            for (int c = 0; c < gap; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    obs[x] = col_addr;
                    n_cmp++;
                    if (col_addr !== exp_col) begin
                        n_err++;
                        $display("FAIL scan x=%0d: col_addr=%h expected %h", x, col_addr, exp_col);
                    end
                end
                if (c == 0 && x == rst_at) begin
                    pxl_cen = 1'b0; wr_valid = 1'b0; rst = 1'b1;
                    #1;
                    n_cmp++;
                    if (col_addr !== C_BG) begin
                        n_err++;
                        $display("FAIL rst_mid col_addr: got %h expected %h", col_addr, C_BG);
                    end
                    n_cmp++;
                    if (wr_ready !== 1'b0 || line_start !== 1'b0) begin
                        n_err++;
                        $display("FAIL rst_mid ctl: wr_ready=%b line_start=%b expected 0 0", wr_ready, line_start);
                    end
                    return;
                end
                LHBL    = 1'b1;
                hdump   = 8'(x);
                pxl_cen = (c == 0);
                if (c == 0) begin
                    rb = ~m_wb;
                    exp_col = hold_m;
                    hold_m  = m_bank[rb][x];
                    m_bank[rb][x] = C_BG;
                end
                drive_rand_write(prob);
            end
        end
        @(negedge clk);
        pxl_cen = 1'b0; wr_valid = 1'b0;
    endtask

    // Horizontal blank starting with the LHBL falling edge
    task automatic hblank(input bit collide, input int prob);
        int ls_cnt  = 0;
        int rdy_low = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            LHBL    = 1'b0;
            pxl_cen = (i % 4 == 2);
            if (i == 0) m_wb = ~m_wb;
            if (collide && i < 2) begin
                wr_valid = 1'b1; wr_addr = 8'd5; wr_data = 8'h11;
                if (i == 1) m_bank[m_wb][5] = 8'h11;
            end else if (i == 0) begin
                wr_valid = 1'b0;
            end else begin
                drive_rand_write(prob);
            end
            #1;
            if (line_start === 1'b1) ls_cnt++;
            if (wr_ready !== 1'b1) rdy_low++;
            if (i % 4 == 3) begin
                n_cmp++;
                if (col_addr !== C_BG) begin
                    n_err++;
                    $display("FAIL blank_col i=%0d: col_addr=%h expected %h", i, col_addr, C_BG);
                end
            end
        end
        @(negedge clk);
        wr_valid = 1'b0; pxl_cen = 1'b0;
        n_cmp++;
        if (ls_cnt != 1) begin
            n_err++;
            $display("FAIL blank_line_start: %0d pulses, expected 1", ls_cnt);
        end
        n_cmp++;
        if (rdy_low != 1) begin
            n_err++;
            $display("FAIL blank_ready: wr_ready low %0d cycles, expected 1", rdy_low);
        end
    endtask

    task automatic check_nonbg(input string tag, input int expv);
        int n;
        n = count_nonbg();
        n_cmp++;
        if (n != expv) begin
            n_err++;
            $display("FAIL %s nonbg_count: got %0d expected %0d", tag, n, expv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; hdump = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (col_addr !== C_BG) begin
            n_err++;
            $display("FAIL reset col_addr: got %h expected %h", col_addr, C_BG);
        end
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset wr_ready: got %b expected 0", wr_ready);
        end
        n_cmp++;
        if (line_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset line_start: got %b expected 0", line_start);
        end
        rst = 1'b0;
        wait_clear("reset");
        model_reset();
    endtask

    task automatic test_clear_readback();
        scan_line(0, -1);
        check_nonbg("clear_bank1", 0);
        hblank(1'b0, 0);
        scan_line(0, -1);
        check_nonbg("clear_bank0", 0);
    endtask

    task automatic test_write_scan();
        do_write(8'd10, 8'h25);
        do_write(8'd11, 8'h37);
        hblank(1'b0, 0);
        scan_line(0, -1);
        n_cmp++;
        if (obs[11] !== 8'h25 || obs[12] !== 8'h37) begin
            n_err++;
            $display("FAIL write_scan: got %h %h expected 25 37", obs[11], obs[12]);
        end
        check_nonbg("write_scan", 2);
    endtask

    task automatic test_transparency();
        do_write(8'd20, 8'h42);
        do_write(8'd20, 8'h5F);
        hblank(1'b0, 0);
        scan_line(0, -1);
        n_cmp++;
        if (obs[21] !== 8'h42) begin
            n_err++;
            $display("FAIL transp: got %h expected 42", obs[21]);
        end
        check_nonbg("transp", 1);
    endtask

    task automatic test_erase();
        hblank(1'b0, 0);
        scan_line(0, -1);
        check_nonbg("erase_l2", 0);
        hblank(1'b0, 0);
        scan_line(0, -1);
        check_nonbg("erase_l3", 0);
    endtask

    task automatic test_swap_collision();
        hblank(1'b1, 0);
        scan_line(0, -1);
        n_cmp++;
        if (obs[6] !== C_BG) begin
            n_err++;
            $display("FAIL collide_early: got %h expected %h", obs[6], C_BG);
        end
        hblank(1'b0, 0);
        scan_line(0, -1);
        n_cmp++;
        if (obs[6] !== 8'h11) begin
            n_err++;
            $display("FAIL collide_late: got %h expected 11", obs[6]);
        end
    endtask

    task automatic test_random();
        for (int l = 0; l < 6; l++) begin
            hblank(1'b0, 30);
            scan_line(30, -1);
        end
    endtask

    task automatic test_reset_midscan();
        for (int x = 50; x < 100; x++) do_write(8'(x), 8'h3C);
        hblank(1'b0, 0);
        scan_line(50, 100);
        @(negedge clk);
        rst = 1'b0;
        wait_clear("rst_mid");
        model_reset();
        scan_line(0, -1);
        check_nonbg("rst_mid_b1", 0);
        hblank(1'b0, 0);
        scan_line(0, -1);
        check_nonbg("rst_mid_b0", 0);
    endtask

    initial begin
        test_reset();
        test_clear_readback();
        test_write_scan();
        test_transparency();
        test_erase();
        test_swap_collision();
        test_random();
        test_reset_midscan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtbubl_obj_linebuf.md
# jtbubl_obj_linebuf

Double-buffered object line buffer between the object draw engine and the colour mixer. The draw engine writes 8-bit colour indices for line N+1 into one bank while the other bank is scanned out, one pixel per `pxl_cen`, as `col_addr` for line N. Banks swap at each start of horizontal blanking. Every scanned location is erased to background right after it is read.

## Interface
Parameters:
- `BG`, 8'hFF: background/erase value, and the value driven on `col_addr` during blanking.
- `TRANSP`, 4'hF: pen nibble (`wr_data[3:0]`) that marks a transparent pixel; such pixels are never written.

Ports:
- `clk`  in  1  single clock for the whole block
- `rst`  in  1  reset, asynchronous, active-high
- `pxl_cen`  in  1  pixel clock enable; consecutive pulses are at least 3 `clk` cycles apart
- `LHBL`  in  1  horizontal blank, active low; its falling edge swaps the banks
- `hdump`  in  8  pixel x counter for the line being displayed
- `wr_addr`  in  8  x position of the write
- `wr_data`  in  8  colour index to write
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready`
- `line_start`  out  1  one-`clk` pulse on the swap cycle; tells the draw engine to start the next line
- `col_addr`  out  8  colour index to the colour mixer

## Operation
- Storage: 512×8 dual-port RAM, address = {bank, x}.
  - Port 0 is the writer port, using bank `wbank`.
  - Port 1 is the read/erase port, using bank `~wbank`.
- Reset values: `wbank`=0, `wr_ready`=0, `line_start`=0, `col_addr`=`BG`, reader state = CLEAR.
- Main states:
  - CLEAR: an 8-bit counter writes `BG` to x=0..255 in both banks. Port 0 and port 1 each write one location per `clk`, so the state lasts 256 cycles. It then moves to RUN.
  - RUN: `wr_ready`=1, except on the swap cycle.
- Writer: an accepted write with `wr_data[3:0]`≠`TRANSP` stores `wr_data` at {wbank, wr_addr}.
  - A transparent write is accepted but discarded.
  - The last write to an address wins; the block does no priority logic of its own.
- Swap: on the first `clk` where the registered `LHBL` is 1 and the live `LHBL` is 0:
  - `wbank` toggles.
  - `line_start` pulses.
  - `wr_ready` is 0 for that cycle.
- Reader sub-FSM (runs only in RUN while `LHBL`=1):
  - IDLE → READ on `pxl_cen`: address {~wbank, hdump} is presented, and the previous hold register is moved to `col_addr`.
  - READ → CAPT: RAM data is latched into the hold register.
  - CAPT → ERASE: `BG` is written to the same address.
  - ERASE → IDLE.
- While `LHBL`=0:
  - The reader stays in IDLE and does not erase.
  - `col_addr` is forced to `BG` on each `pxl_cen`.
  - The hold register is reset to `BG`.

## Timing
- Output latency: the pixel for `hdump`=N appears on `col_addr` at the `pxl_cen` that samples `hdump`=N+1. This is exactly one pixel of delay; the colour mixer's blank delay absorbs it.
- The first `pxl_cen` after `LHBL` rises outputs `BG`, because the hold register was cleared during blanking.
- Erase finishes 3 `clk` after the `pxl_cen`, before the next pulse, so each x is cleared exactly once per line.
- The writer never shares a bank with the reader, so a write and a read/erase in the same cycle never conflict.
- A `pxl_cen` on the swap cycle is treated as a blanking pixel.
- A write request on the swap cycle stalls (`wr_ready`=0) and lands in the new `wbank` on the next cycle.
- `rst` asserted mid-line:
  - All outputs return to their reset values immediately.
  - CLEAR restarts from x=0.
  - RAM contents are then considered background after 256 cycles.
- `hdump` wrap 255→0 needs no special handling; the 8-bit address simply wraps.

## Structure
- Shared package `jtbubl_obj_pkg` holds:
  - the `BG` and `TRANSP` defaults,
  - the reader state encoding (CLEAR, IDLE, READ, CAPT, ERASE).
- Single sub-module: `jtframe_dual_ram` with aw=9, both ports on `clk`.
- Swap-edge detection, the CLEAR counter and the reader FSM live in this module.

## Test plan
- Reset clear: release `rst`.
  - `wr_ready` stays 0 for 256 cycles, then goes 1.
  - Reading any x on both banks returns 8'hFF.
- Write/scan: in line 0, write x=10 with 8'h25 and x=11 with 8'h37, then swap.
  - In line 1, `col_addr`=8'h25 at the `pxl_cen` sampling `hdump`=11, and 8'h37 at the one sampling `hdump`=12.
  - All other pixels read 8'hFF.
- Transparency: write x=20 with 8'h42, then write x=20 with 8'h5F.
  - The scan shows 8'h42 at x=20.
- Erase: scan line 1 containing data, swap twice without any writes.
  - Line 3 scans all 8'hFF.
- Swap collision: hold `wr_valid` with x=5, 8'h11 across the `LHBL` falling edge.
  - `wr_ready` is 0 for exactly 1 cycle and `line_start` pulses once.
  - 8'h11 appears in the line after the one currently being filled.
- Reset mid-scan: assert `rst` at `hdump`=100.
  - `col_addr`=8'hFF immediately.
  - After the CLEAR sweep, both banks read 8'hFF.
